// File: rtl/dmem_responder.sv
// dmem_responder: target end of the CPU data load/store request path.
// It accepts one request at a time, holds it for WAIT_CYCLES wait states, and
// then completes it with a one-cycle resp_done pulse. Loads also return read data.
// Optional build macro DMEM_RESPONDER_ADDR_CHECK_EN flags any address with
// nonzero bits above the storage index. When that macro is undefined, the
// address wraps and resp_err is tied low.
module dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_done,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  cap_write;
  logic [DEPTH_LOG2-1:0] cap_idx;
  logic [31:0]           cap_wdata;
  logic                  cap_err;

  logic [31:0]           mem [0:DEPTH-1];

  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  addr_err;
  logic                  enter_resp;
  logic                  rd_write;
  logic                  rd_err;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign acc_idx = req_addr[DEPTH_LOG2-1:0];

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
  assign addr_err = |req_addr[31:DEPTH_LOG2];
`else
  logic unused_addr_hi;
  assign unused_addr_hi = |req_addr[31:DEPTH_LOG2];
  assign addr_err       = 1'b0;
  assign resp_err       = 1'b0;
`endif

  // Decide when RESP is entered, and which request (live or captured) feeds it.
  // With zero wait states, RESP is entered straight from IDLE. In that case the
  // response must come from the live request inputs, because the capture
  // registers are loaded on the same edge.
  always_comb begin
    enter_resp = 1'b0;
    rd_write   = cap_write;
    rd_err     = cap_err;
    rd_idx     = cap_idx;
    if (state == IDLE) begin
      enter_resp = req_valid && (WAIT_CYCLES == 0);
      rd_write   = req_write;
      rd_err     = addr_err;
      rd_idx     = acc_idx;
    end else if (state == WAIT) begin
      enter_resp = (cnt == 4'd0);
    end
  end

  // Request sequencing FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_done  <= 1'b0;
      resp_rdata <= '0;
      cnt        <= '0;
      cap_write  <= 1'b0;
      cap_idx    <= '0;
      cap_wdata  <= '0;
      cap_err    <= 1'b0;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
      resp_err   <= 1'b0;
`endif
    end else begin
      resp_done <= 1'b0;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
      resp_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_write <= req_write;
            cap_idx   <= acc_idx;
            cap_wdata <= req_wdata;
            cap_err   <= addr_err;
            req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase

      if (enter_resp) begin
        resp_done <= 1'b1;
`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
        resp_err  <= rd_err;
`endif
        if (!rd_write) begin
          resp_rdata <= rd_err ? '0 : mem[rd_idx];
        end
      end
    end
  end

  // Commit a store on the edge that leaves RESP. The store is dropped if a reset
  // arrives on that edge or if the request was flagged as an address error.
  always_ff @(posedge clk) begin
    if (!rst && (state == RESP) && cap_write && !cap_err) begin
      mem[cap_idx] <= cap_wdata;
    end
  end

endmodule
